// File: rtl/sdram_load_writer.sv
// sdram_load_writer: downstream stage of the SD-card loader.
// Accepts the loader's 16-bit word stream, buffers it in a small FIFO and
// replays each word as an Avalon-MM master write into the SDRAM controller.
// Reports completion once the loader is done and every buffered word is
// committed, or a sticky error when the loader reports an SD init failure.
//
// Optional feature macro: LOAD_CHECKSUM_EN adds a 16-bit running sum of the
// committed write data on port checksum (frozen once DONE or ERR is reached).
`timescale 1ns/1ps

module sdram_load_writer #(
    parameter int unsigned FIFO_DEPTH = 8,      // power of 2, >= 2
    parameter logic [24:0] BASE_ADDR  = 25'h0
) (
    input  logic        clk50,
    input  logic        reset_n,
    // Loader side
    input  logic        ram_we,
    input  logic [24:0] ram_address,
    input  logic [15:0] ram_data,
    output logic        ram_op_begun,
    input  logic        ram_init_done,
    input  logic        ram_init_error,
    // Avalon-MM master
    output logic [24:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    output logic [1:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    // Status
    output logic        load_done,
    output logic        load_error,
`ifdef LOAD_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic [24:0] words_written
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    // FIFO storage; entries hold the already-offset SDRAM address
    logic [24:0]   addr_mem [FIFO_DEPTH];
    logic [15:0]   data_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // A write that was stalled last cycle must stay asserted, even in ERR
    logic          hold_q, hold_d;

    logic          load_done_q, load_done_d;
    logic          load_error_q, load_error_d;
    logic [24:0]   words_q, words_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          flush;

    // FIFO status; depth is a power of two so the count MSB marks full
    always_comb begin
        fifo_full  = count_q[AW];
        fifo_empty = (count_q == '0);
    end

    // Loader acknowledge and Avalon outputs
    always_comb begin
        ram_op_begun   = ram_we & ~fifo_full & (state_q == StRun);
        avm_write      = (state_q == StErr) ? hold_q : ~fifo_empty;
        avm_address    = '0;
        avm_writedata  = '0;
        if (avm_write) begin
            avm_address   = addr_mem[rd_ptr_q];
            avm_writedata = data_mem[rd_ptr_q];
        end
        avm_byteenable = {2{avm_write}};
        push           = ram_op_begun;
        pop            = avm_write & ~avm_waitrequest;
        // In ERR everything queued is dropped once no write is stalled on the bus
        flush          = (state_q == StErr) & ~(avm_write & avm_waitrequest);
    end

    // Next-state logic for the load sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (ram_init_done) state_d = StDrain;
            StDrain: if (fifo_empty && !avm_write) state_d = StDone;
            default: state_d = state_q;
        endcase
        // DONE and ERR are terminal; the error has priority everywhere else
        if (ram_init_error && (state_q != StDone) && (state_q != StErr)) begin
            state_d = StErr;
        end
    end

    // FIFO pointer / occupancy and status next-state
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hold_d       = avm_write & avm_waitrequest;
        words_d      = words_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end

        if (pop) words_d = words_q + 25'd1;
        if (state_d == StDone) load_done_d = 1'b1;
        if (state_d == StErr)  load_error_d = 1'b1;
    end

    // State and control registers
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= 1'b0;
            words_q      <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            words_q      <= words_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    // FIFO storage write; contents are don't-care until pushed
    always_ff @(posedge clk50) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= ram_address + BASE_ADDR;
            data_mem[wr_ptr_q] <= ram_data;
        end
    end

    always_comb begin
        load_done     = load_done_q;
        load_error    = load_error_q;
        words_written = words_q;
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Running sum of committed data, frozen in the terminal states
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if (pop && (state_q != StDone) && (state_q != StErr)) begin
            checksum_q <= checksum_q + avm_writedata;
        end
    end

    always_comb begin
        checksum = checksum_q;
    end
`endif

endmodule
